// File: rtl/alu_muldiv.sv
// Execute-stage ALU: registered single-cycle logic/arithmetic ops plus
// iterative radix-2 multiply/divide that write the HI/LO register pair.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             out_valid,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t state, state_nxt;

    logic             accept;
    logic             is_md;
    logic             op_signed;
    logic [WIDTH-1:0] single_res;

    // Iteration registers: counter, magnitudes, partial product / remainder
    logic [CNT_W-1:0] cnt_p0;
    logic [WIDTH-1:0] mcand_p0;
    logic [WIDTH-1:0] acc_hi_p0;
    logic [WIDTH-1:0] acc_lo_p0;
    logic [WIDTH-1:0] a_p0;
    logic             is_div_p0;
    logic             neg_q_p0;
    logic             neg_r_p0;
    logic             dz_p0;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ok;
    logic [WIDTH-1:0] hi_fin;
    logic [WIDTH-1:0] lo_fin;

    // Architectural outputs
    logic [WIDTH-1:0] result_p1;
    logic             zero_p1;
    logic             vld_p1;
    logic             dz_p1;
    logic [WIDTH-1:0] hi_p1;
    logic [WIDTH-1:0] lo_p1;

    // Magnitude of an operand; unsigned ops pass the raw value through.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        logic signed [WIDTH-1:0] vs;
        vs = v;
        if (sgn && vs < 0)
            return WIDTH'(-vs);
        return v;
    endfunction

    // Result of the single-cycle opcodes; HI/LO reads see the pre-accept values.
    function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] f,
                                                    input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y,
                                                    input logic [WIDTH-1:0] h,
                                                    input logic [WIDTH-1:0] l);
        logic signed [WIDTH-1:0] xs;
        logic signed [WIDTH-1:0] ys;
        xs = x;
        ys = y;
        case (f)
            4'd0:    return x + y;
            4'd1:    return x - y;
            4'd2:    return x & y;
            4'd3:    return x | y;
            4'd4:    return {{(WIDTH-1){1'b0}}, (xs < ys)};
            4'd5:    return x ^ y;
            4'd6:    return ~(x | y);
            4'd7:    return {{(WIDTH-1){1'b0}}, (x < y)};
            4'd12:   return h;
            4'd13:   return l;
            default: return x;
        endcase
    endfunction

    assign accept    = in_valid && (state == IDLE);
    assign is_md     = (op[3:2] == 2'b10);
    assign op_signed = ~op[0];
    assign busy      = (state != IDLE);

    assign result      = result_p1;
    assign zero        = zero_p1;
    assign out_valid   = vld_p1;
    assign div_by_zero = dz_p1;
    assign hi          = hi_p1;
    assign lo          = lo_p1;

    // Single-cycle result for the opcode currently presented
    always_comb begin
        single_res = alu_single(op, a, b, hi_p1, lo_p1);
    end

    // One radix-2 step: shift-add multiply and restoring-divide trial subtract
    always_comb begin
        mul_sum   = {1'b0, acc_hi_p0} + (acc_lo_p0[0] ? {1'b0, mcand_p0} : '0);
        div_shift = {acc_hi_p0, acc_lo_p0[WIDTH-1]};
        div_ok    = (div_shift >= {1'b0, mcand_p0});
    end

    // Sign fix-up and divide-by-zero override applied on the way out of FIN
    always_comb begin
        logic [2*WIDTH-1:0] prod;
        prod   = {acc_hi_p0, acc_lo_p0};
        hi_fin = '0;
        lo_fin = '0;
        if (is_div_p0) begin
            if (dz_p0) begin
                hi_fin = a_p0;
                lo_fin = '1;
            end else begin
                lo_fin = neg_q_p0 ? -acc_lo_p0 : acc_lo_p0;
                hi_fin = neg_r_p0 ? -acc_hi_p0 : acc_hi_p0;
            end
        end else begin
            if (neg_q_p0)
                prod = -prod;
            {hi_fin, lo_fin} = prod;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state: IDLE -> RUN for WIDTH steps -> FIN -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_md) state_nxt = RUN;
            RUN:     if (cnt_p0 == CNT_W'(WIDTH - 1)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control and architectural outputs: counter, result/zero, valid pulse, HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0    <= '0;
            result_p1 <= '0;
            zero_p1   <= 1'b1;
            vld_p1    <= 1'b0;
            dz_p1     <= 1'b0;
            hi_p1     <= '0;
            lo_p1     <= '0;
        end else begin
            vld_p1 <= 1'b0;
            dz_p1  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt_p0 <= '0;
                        if (!is_md) begin
                            result_p1 <= single_res;
                            zero_p1   <= (single_res == '0);
                            vld_p1    <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    cnt_p0 <= cnt_p0 + CNT_W'(1);
                end
                FIN: begin
                    hi_p1     <= hi_fin;
                    lo_p1     <= lo_fin;
                    result_p1 <= lo_fin;
                    zero_p1   <= (lo_fin == '0);
                    vld_p1    <= 1'b1;
                    dz_p1     <= dz_p0;
                end
                default: ;
            endcase
        end
    end

    // Iteration datapath: latch magnitudes at accept, then one step per RUN cycle
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (accept && is_md) begin
                    acc_hi_p0 <= '0;
                    acc_lo_p0 <= mag(a, op_signed);
                    mcand_p0  <= mag(b, op_signed);
                    a_p0      <= a;
                    is_div_p0 <= op[1];
                    neg_q_p0  <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_r_p0  <= op_signed && a[WIDTH-1];
                    dz_p0     <= op[1] && (b == '0);
                end
            end
            RUN: begin
                if (is_div_p0) begin
                    if (div_ok) begin
                        acc_hi_p0 <= WIDTH'(div_shift - {1'b0, mcand_p0});
                        acc_lo_p0 <= {acc_lo_p0[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_p0 <= div_shift[WIDTH-1:0];
                        acc_lo_p0 <= {acc_lo_p0[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_p0 <= mul_sum[WIDTH:1];
                    acc_lo_p0 <= {mul_sum[0], acc_lo_p0[WIDTH-1:1]};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: stimulus pushes reference-model results,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_alu_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] result;
    logic         zero;
    logic         out_valid;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .a(a), .b(b),
        .result(result), .zero(zero), .out_valid(out_valid), .busy(busy),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           ecyc;
    } exp_t;

    exp_t         sbq[$];
    exp_t         mon_h;
    int           cyc = 0;
    int           md_free = 0;
    int           vectors = 0;
    int           miscompares = 0;
    logic [W-1:0] hi_m = '0;
    logic [W-1:0] lo_m = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain arithmetic on 64-bit values, HI/LO as two variables
    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        longint      p;
        longint      q;
        longint      r;
        logic [63:0] u;
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        step();
        in_valid = 1'b0;
        if (cyc >= md_free) begin
            e.dz = 1'b0;
            e.ecyc = cyc;
            e.res = x;
            case (o)
                4'd0:  e.res = x + y;
                4'd1:  e.res = x - y;
                4'd2:  e.res = x & y;
                4'd3:  e.res = x | y;
                4'd4:  e.res = ($signed(x) < $signed(y)) ? 1 : 0;
                4'd5:  e.res = x ^ y;
                4'd6:  e.res = ~(x | y);
                4'd7:  e.res = (x < y) ? 1 : 0;
                4'd12: e.res = hi_m;
                4'd13: e.res = lo_m;
                4'd8: begin
                    p = longint'($signed(x)) * longint'($signed(y));
                    {hi_m, lo_m} = p;
                end
                4'd9: begin
                    u = {32'b0, x} * {32'b0, y};
                    {hi_m, lo_m} = u;
                end
                4'd10, 4'd11: begin
                    if (y == 0) begin
                        hi_m = x;
                        lo_m = '1;
                        e.dz = 1'b1;
                    end else if (o == 4'd10) begin
                        q = longint'($signed(x)) / longint'($signed(y));
                        r = longint'($signed(x)) % longint'($signed(y));
                        lo_m = q[31:0];
                        hi_m = r[31:0];
                    end else begin
                        lo_m = x / y;
                        hi_m = x % y;
                    end
                end
                default: e.res = x;
            endcase
            if (o >= 4'd8 && o <= 4'd11) begin
                e.res = lo_m;
                e.ecyc = cyc + W + 1;
                md_free = cyc + W + 2;
            end
            e.hi = hi_m;
            e.lo = lo_m;
            sbq.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        sbq.delete();
        md_free = 0;
        hi_m = '0;
        lo_m = '0;
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && cyc < md_free; i++) step();
        chk("wait_idle_timeout", 64'(cyc >= md_free), 64'd1);
    endtask

    function automatic logic [W-1:0] rnd();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'd1;
            2: return '1;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: busy shape every cycle, scoreboard pop on every out_valid
    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(cyc < md_free - 1));
        if (out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                mon_h = sbq.pop_front();
                chk("latency", 64'(cyc), 64'(mon_h.ecyc));
                chk("result", 64'(result), 64'(mon_h.res));
                chk("zero", 64'(zero), 64'(mon_h.res == 0));
                chk("hi", 64'(hi), 64'(mon_h.hi));
                chk("lo", 64'(lo), 64'(mon_h.lo));
                chk("div_by_zero", 64'(div_by_zero), 64'(mon_h.dz));
            end
        end else begin
            if (div_by_zero !== 1'b0)
                chk("div_by_zero_idle", 64'(div_by_zero), 64'd0);
            if (sbq.size() > 0 && sbq[0].ecyc <= cyc) begin
                chk("missing_out_valid", 64'd0, 64'd1);
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
        $fatal(1, "watchdog expired");
    end

    initial begin
        step();
        do_reset();
        @(negedge clk);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_zero", 64'(zero), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        @(posedge clk);
        #1;

        issue(4'd0, 32'h7FFF_FFFF, 32'd1);
        issue(4'd1, 32'd5, 32'd5);
        issue(4'd4, 32'hFFFF_FFFF, 32'd1);
        issue(4'd7, 32'hFFFF_FFFF, 32'd1);
        issue(4'd6, 32'd0, 32'd0);
        issue(4'd5, 32'hF0F0_1234, 32'h0FF0_FFFF);

        // mult -3 x 7, add requests held during RUN, mflo in the completion cycle
        issue(4'd8, 32'hFFFF_FFFD, 32'd7);
        for (int i = 0; i < 10; i++) issue(4'd0, 32'd1, 32'd2);
        for (int i = 0; i < 100 && cyc < md_free - 1; i++) step();
        issue(4'd13, 32'd0, 32'd0);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);

        issue(4'd9, 32'hFFFF_FFFF, 32'd2);
        wait_idle();
        chk("multu_hi", 64'(hi), 64'd1);
        chk("multu_lo", 64'(lo), 64'hFFFF_FFFE);

        issue(4'd10, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);

        issue(4'd10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        chk("divmin_lo", 64'(lo), 64'h8000_0000);
        chk("divmin_hi", 64'(hi), 64'd0);

        issue(4'd11, 32'd7, 32'd0);
        wait_idle();
        chk("divz_hi", 64'(hi), 64'd7);
        chk("divz_lo", 64'(lo), 64'hFFFF_FFFF);
        issue(4'd12, 32'd0, 32'd0);

        // mfhi in the completion cycle of a mult sees the new HI
        issue(4'd8, 32'h1234_5678, 32'h8765_4321);
        for (int i = 0; i < 100 && cyc < md_free - 1; i++) step();
        issue(4'd12, 32'd0, 32'd0);

        // reset during RUN of a divu aborts it
        issue(4'd11, 32'd1000, 32'd3);
        for (int i = 0; i < 9; i++) step();
        do_reset();
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        issue(4'd11, 32'd100, 32'd7);
        wait_idle();
        chk("divu_lo", 64'(lo), 64'd14);
        chk("divu_hi", 64'(hi), 64'd2);

        // randomized traffic, requests while busy are dropped by design
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 8)
                issue(4'($urandom_range(0, 15)), rnd(), rnd());
            else
                step();
        end

        for (int i = 0; i < 100 && sbq.size() > 0; i++) step();
        chk("drain", 64'(sbq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised, registered execute-stage ALU for the pipelined MIPS core. Single-cycle logic/arithmetic ops plus iterative signed/unsigned multiply and divide writing internal HI/LO registers. Multi-cycle ops assert `busy` so the hazard unit stalls the pipeline until completion.

## Interface
- `WIDTH`, 32: operand, result, HI and LO width; must be ≥ 4.
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operation request; accepted only when `busy`=0.
- `op` in 4: 0 add, 1 sub, 2 and, 3 or, 4 slt (signed), 5 xor, 6 nor, 7 sltu, 8 mult, 9 multu, 10 div, 11 divu, 12 mfhi, 13 mflo; 14–15 pass `a`.
- `a`, `b` in WIDTH: operands; `a` is rs/dividend, `b` is rt/divisor.
- `result` out WIDTH: registered result.
- `zero` out 1: registered; 1 iff `result`==0.
- `out_valid` out 1: one-cycle pulse marking a new `result`.
- `busy` out 1: multi-cycle op in flight; requests ignored.
- `hi`, `lo` out WIDTH: architectural HI/LO registers.
- `div_by_zero` out 1: pulses with `out_valid` of a div/divu whose `b`==0.

## Operation
- Accept = `in_valid` & !`busy` at a rising edge; `op`, `a`, `b` captured there. Non-accepted requests are dropped; no queuing.
- Ops 0–7, 12–15 (single-cycle): `result`, `zero` loaded at the accept edge; `out_valid`=1 for the following cycle. Add/sub wrap modulo 2^WIDTH, no overflow flag. slt/sltu yield 1 or 0, zero-extended. mfhi/mflo return HI/LO as they stood before the accept edge.
- Ops 8–11: FSM IDLE → RUN → FIN → IDLE.
  - IDLE: accept of op 8–11 → RUN; counter cleared; operand magnitudes latched (signed ops take |a|, |b| and record result signs; unsigned use raw values).
  - RUN: one radix-2 step per cycle (shift-add multiply / restoring divide); exactly WIDTH cycles, then → FIN.
  - FIN: sign fix-up; at exit edge HI/LO written, `result`=LO, `zero` updated, `out_valid`=1 next cycle, → IDLE.
- Multiply: {HI,LO} = full 2·WIDTH-bit product.
- Divide: LO = quotient truncated toward zero; HI = remainder, sign of dividend.
- `b`==0: HI=`a`, LO=all ones, `div_by_zero`=1; timing unchanged.
- Signed MIN ÷ −1: LO=MIN, HI=0, no flag.
- HI/LO change only at FIN exit or reset.

## Timing
- Reset: `result`=0, `zero`=1, `out_valid`=0, `busy`=0, `div_by_zero`=0, `hi`=`lo`=0, FSM=IDLE, counter=0.
- Single-cycle latency: 1 edge. Back-to-back issue allowed every cycle.
- Multi-cycle: accept at edge N; `busy`=1 from after edge N through edge N+WIDTH+1; HI/LO/`result` valid and `out_valid`=1 in the cycle after edge N+WIDTH+1 (latency WIDTH+1; 33 for WIDTH=32).
- `busy`=0 in the `out_valid` cycle; a new op may be accepted there.
- `out_valid` held 0 throughout RUN/FIN; `result`/`zero` hold the last value.
- `rst` mid-operation: aborts, FSM → IDLE, all outputs to reset values at that edge; reset wins over a simultaneous accept.
- mfhi issued in the `out_valid` cycle of a mult returns the new HI.

## Test plan
- Reset, then add 0x7FFFFFFF+1 → next cycle `result`=0x80000000, `zero`=0, `out_valid`=1; sub 5−5 → `result`=0, `zero`=1.
- slt a=0xFFFFFFFF, b=1 → 1; sltu same operands → 0; nor 0,0 → 0xFFFFFFFF.
- mult −3×7 → `busy` 33 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, `result`=0xFFFFFFEB; multu 0xFFFFFFFF×2 → `hi`=1, `lo`=0xFFFFFFFE.
- div −7÷2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; div 0x80000000÷0xFFFFFFFF → `lo`=0x80000000, `hi`=0; divu 7÷0 → `hi`=7, `lo`=0xFFFFFFFF, `div_by_zero`=1.
- `in_valid` add held during mult RUN → ignored, no `out_valid` until completion; mflo issued in the completion cycle → returns new LO next cycle.
- Assert `rst` at RUN cycle 10 of a divu → `busy`=0, `hi`=`lo`=0, no `out_valid`; next divu 100÷7 → `lo`=14, `hi`=2.
